// File: rtl/stream_tools_pkg.sv
// Shared encodings and header layout for the stream_tools framer/holder pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stream_tools_pkg;

  typedef enum logic [2:0] {
    ST_FILL    = 3'd0,
    ST_DROP    = 3'd1,
    ST_HDR0    = 3'd2,
    ST_HDR1    = 3'd3,
    ST_PAYLOAD = 3'd4
  } state_t;

  localparam int HDR_BEATS = 2;
  localparam int ADDR_W    = 48;
  localparam int LEN_W     = 16;

  // Beat 0 carries the upper 32 address bits in its low word.
  localparam int HDR0_ADDR_W   = 32;
  // Beat 1 carries {len-1, addr[15:0]} in its low word.
  localparam int HDR1_ADDR_W   = 16;
  localparam int HDR1_LEN_LSB  = 16;

endpackage

// File: rtl/packet_framer_ram.sv
// Payload store: one synchronous write port, one asynchronous read port.
// Latency: write visible on the edge after wr_en; read is combinational.
// Backpressure: none; the caller owns all flow control.
module packet_framer_ram
  import stream_tools_pkg::*;
#(
  parameter int depth  = 256,
  parameter int width  = 32,
  parameter int addr_w = $clog2(depth)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [addr_w-1:0] wr_addr,
  input  logic [width-1:0]  wr_data,
  input  logic [addr_w-1:0] rd_addr,
  output logic [width-1:0]  rd_data
);

  logic [width-1:0] mem [depth];

  // Storage is deliberately left unreset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/packet_framer.sv
// Store-and-forward framer: buffers one payload, emits {dest hi, len/dest lo} header then payload.
// Latency: first header beat valid the cycle after the i_last handshake.
// Backpressure: i_ready low while emitting; outputs hold while o_valid && !o_ready.
module packet_framer
  import stream_tools_pkg::*;
#(
  parameter int max_packet_length = 256,
  parameter int stream_w          = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [stream_w-1:0] i_stream,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic                i_last,
  input  logic [ADDR_W-1:0]   i_dest_addr,
  output logic [stream_w-1:0] o_stream,
  output logic                o_valid,
  input  logic                o_ready,
  output logic                o_last,
  output logic                error_packet_too_long,
  input  logic                clear_errors,
  output logic                busy
);

  localparam int AW = $clog2(max_packet_length);
  // One extra bit so a completely full buffer length is representable.
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(max_packet_length - 1);

  state_t state, state_nxt;

  logic [CW-1:0]       wr_cnt, rd_ptr, len, len_m1;
  logic [ADDR_W-1:0]   dest;
  logic [LEN_W-1:0]    len_field;
  logic [stream_w-1:0] hdr0_dat, hdr1_dat, ram_rd_dat;
  logic                i_hs, o_hs, wr_en, overflow;

  assign i_hs     = i_valid && i_ready;
  assign o_hs     = o_valid && o_ready;
  assign wr_en    = (state == ST_FILL) && i_hs;
  assign overflow = wr_en && !i_last && (wr_cnt == LAST_SLOT);
  assign busy     = (state != ST_FILL);

  assign len_m1    = len - ONE;
  assign len_field = LEN_W'(len_m1);
  assign hdr0_dat  = stream_w'(dest[ADDR_W-1 -: HDR0_ADDR_W]);
  assign hdr1_dat  = stream_w'({len_field, dest[HDR1_ADDR_W-1:0]});

  packet_framer_ram #(
    .depth (max_packet_length),
    .width (stream_w)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt[AW-1:0]),
    .wr_data (i_stream),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_rd_dat)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_FILL;
    else      state <= state_nxt;
  end

  // Next-state and output decode; outputs depend only on registered state so they hold under stall.
  always_comb begin
    state_nxt = state;
    i_ready   = 1'b0;
    o_valid   = 1'b0;
    o_last    = 1'b0;
    o_stream  = '0;
    case (state)
      ST_FILL: begin
        i_ready = 1'b1;
        if (i_valid) begin
          if (i_last)                   state_nxt = ST_HDR0;
          else if (wr_cnt == LAST_SLOT) state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        i_ready = 1'b1;
        if (i_valid && i_last) state_nxt = ST_FILL;
      end
      ST_HDR0: begin
        o_valid  = 1'b1;
        o_stream = hdr0_dat;
        if (o_ready) state_nxt = ST_HDR1;
      end
      ST_HDR1: begin
        o_valid  = 1'b1;
        o_stream = hdr1_dat;
        if (o_ready) state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        o_valid  = 1'b1;
        o_stream = ram_rd_dat;
        o_last   = (rd_ptr == len_m1);
        if (o_ready && o_last) state_nxt = ST_FILL;
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  // Write counter, captured length/destination and read pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= '0;
      rd_ptr <= '0;
      len    <= '0;
      dest   <= '0;
    end else begin
      if (wr_en) begin
        if (i_last) begin
          len    <= wr_cnt + ONE;
          dest   <= i_dest_addr;
          wr_cnt <= wr_cnt + ONE;
        end else if (wr_cnt == LAST_SLOT) begin
          wr_cnt <= '0;
        end else begin
          wr_cnt <= wr_cnt + ONE;
        end
      end
      if (state == ST_HDR1 && o_hs) rd_ptr <= '0;
      if (state == ST_PAYLOAD && o_hs) begin
        if (o_last) begin
          rd_ptr <= '0;
          wr_cnt <= '0;
        end else begin
          rd_ptr <= rd_ptr + ONE;
        end
      end
    end
  end

  // Sticky overflow flag; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              error_packet_too_long <= 1'b0;
    else if (overflow)     error_packet_too_long <= 1'b1;
    else if (clear_errors) error_packet_too_long <= 1'b0;
  end

endmodule
